move_cmd_dispatcher: RTL and testbench
======================================

# move_cmd_dispatcher

Receiving end of the debounced button-pulse interface. Takes single-cycle move pulses from the four button debouncers (left, right, rotate, down). It resolves simultaneous and opposing presses, buffers the resulting commands in a small FIFO, and hands them one at a time to the game core over a valid/ready handshake. It sits between the debouncer bank and the piece-movement state machine.

## Interface
- ADDR_W, default 2: FIFO address width; FIFO depth = 2**ADDR_W (4).
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset; clock clk.
- btn_left_pulse  input  1  one-cycle pulse from left debouncer.
- btn_right_pulse  input  1  one-cycle pulse from right debouncer.
- btn_rotate_pulse  input  1  one-cycle pulse from rotate debouncer.
- btn_down_pulse  input  1  one-cycle pulse from down debouncer.
- flush  input  1  synchronous clear of FIFO and pending flags (piece locked, game over, pause).
- cmd_valid  output  1  FIFO non-empty; cmd_code is meaningful.
- cmd_code  output  2  head command: 0 left, 1 right, 2 rotate, 3 down.
- cmd_ready  input  1  game core accepts head command this cycle.
- fifo_level  output  ADDR_W+1  number of queued commands, 0..2**ADDR_W.
- drop_cnt  output  8  saturating count of discarded pulses.

## Operation
- Pending flags: one register per command (pend_l, pend_r, pend_rot, pend_dn).
  - A pulse sets its flag.
  - If the flag is already set when its pulse arrives, the pulse is dropped and drop_cnt increments.
- Opposing resolution, evaluated before setting flags:
  - btn_left_pulse and btn_right_pulse in the same cycle: both ignored; no flag set; not counted as a drop.
  - Right pulse while pend_l is set (or left pulse while pend_r is set): the pending flag clears and the new pulse is not recorded. This counts as one drop.
- Enqueue:
  - At most one command per cycle, taken from the pending flags registered at the previous edge.
  - Priority: rotate > left > right > down.
  - Allowed only when fifo_level < 2**ADDR_W, regardless of a same-cycle pop.
  - The selected flag clears on enqueue. If a new pulse for that command arrives in the same cycle, the flag stays set: the new pulse is recorded, not dropped.
- FIFO:
  - Circular buffer with rd_ptr and wr_ptr of ADDR_W bits each; pointers wrap modulo depth.
  - fifo_level tracks occupancy; a simultaneous push and pop leaves it unchanged.
- Handshake:
  - cmd_valid = (fifo_level != 0). cmd_code = mem[rd_ptr], driven from registers.
  - Pop on cmd_valid && cmd_ready.
  - cmd_code stays stable while cmd_valid is high and cmd_ready is low.
- flush:
  - Next edge: fifo_level=0, both pointers=0, all pending flags 0.
  - Pulses in the same cycle are discarded and not counted.
  - drop_cnt is unaffected.
- drop_cnt: +1 per dropped pulse, at most +1 per cycle even if several pulses drop in one cycle. Saturates at 255. Cleared only by reset.

## Timing
- Reset values: cmd_valid=0, cmd_code=0, fifo_level=0, drop_cnt=0, pointers=0, all pending flags=0.
- Latency on an empty FIFO:
  - Pulse high in cycle n sets its flag at edge n.
  - Command enqueues at edge n+1.
  - cmd_valid is high in cycle n+1 after that edge, i.e. 2 edges after the pulse is sampled.
- Throughput: one push and one pop per cycle sustained.
- Four simultaneous distinct pulses (no left/right conflict): enqueue on 4 consecutive edges in priority order.
- Full FIFO: pending flags hold; enqueue resumes on the first edge after fifo_level < depth is registered.
- Asynchronous reset mid-operation clears all state immediately. Pending and queued commands are lost.

## Test plan
- Reset then single right pulse, cmd_ready=1 -> cmd_valid high for exactly 1 cycle, 2 edges after the pulse, cmd_code=1; fifo_level returns to 0.
- Rotate, left and down pulses in the same cycle, cmd_ready=0 -> fifo_level reaches 3 over 3 edges. Raising cmd_ready then yields cmd_code sequence 2, 0, 3.
- Left and right pulses in the same cycle -> no command, drop_cnt unchanged. Left pulse, then right pulse while pend_l is still set (FIFO full) -> no command, drop_cnt=1.
- cmd_ready=0, 6 down pulses spaced 3 cycles apart -> fifo_level saturates at 4, one stays pending, one drops (drop_cnt=1). Draining yields 5 commands of code 3.
- FIFO holding 3 commands, assert flush with a concurrent rotate pulse -> next cycle fifo_level=0, cmd_valid=0, no rotate ever issued, drop_cnt unchanged.
- Force 300 dropped pulses -> drop_cnt=255 and stays there. Then assert reset mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/move_cmd_dispatcher.sv
// Move command dispatcher: turns debounced button pulses into a queued stream of
// move commands, resolving opposing presses, and hands them to the game core via valid/ready.
module move_cmd_dispatcher #(
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_left_pulse,
    input  logic              btn_right_pulse,
    input  logic              btn_rotate_pulse,
    input  logic              btn_down_pulse,
    input  logic              flush,
    output logic              cmd_valid,
    output logic [1:0]        cmd_code,
    input  logic              cmd_ready,
    output logic [ADDR_W:0]   fifo_level,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] CODE_LEFT   = 2'd0;
    localparam logic [1:0] CODE_RIGHT  = 2'd1;
    localparam logic [1:0] CODE_ROTATE = 2'd2;
    localparam logic [1:0] CODE_DOWN   = 2'd3;

    logic              pend_l_q, pend_r_q, pend_rot_q, pend_dn_q;
    logic              pend_l_d, pend_r_d, pend_rot_d, pend_dn_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [7:0]        drop_q, drop_d;
    logic [1:0]        mem_q [DEPTH];

    logic       can_push, push, pop;
    logic       enq_l, enq_r, enq_rot, enq_dn;
    logic [1:0] push_code;
    logic       left_only, right_only, rot_in, dn_in;
    logic       set_l, set_r, clr_l, clr_r;
    logic       drop_l, drop_r, drop_rot, drop_dn, any_drop;

    // Enqueue selection from registered flags; rotate > left > right > down.
    always_comb begin
        can_push = ~level_q[ADDR_W];
        enq_rot  = can_push & pend_rot_q;
        enq_l    = can_push & ~pend_rot_q & pend_l_q;
        enq_r    = can_push & ~pend_rot_q & ~pend_l_q & pend_r_q;
        enq_dn   = can_push & ~pend_rot_q & ~pend_l_q & ~pend_r_q & pend_dn_q;
        push     = ~flush & (enq_rot | enq_l | enq_r | enq_dn);
        pop      = ~flush & cmd_valid & cmd_ready;
        push_code = CODE_DOWN;
        if (enq_rot) begin
            push_code = CODE_ROTATE;
        end else if (enq_l) begin
            push_code = CODE_LEFT;
        end else if (enq_r) begin
            push_code = CODE_RIGHT;
        end
    end

    // Pulse resolution; a flush discards every pulse in its cycle.
    always_comb begin
        left_only  = ~flush & btn_left_pulse & ~btn_right_pulse;
        right_only = ~flush & btn_right_pulse & ~btn_left_pulse;
        rot_in     = ~flush & btn_rotate_pulse;
        dn_in      = ~flush & btn_down_pulse;

        // An opposing pending flag cancels; otherwise a still-set flag drops the pulse.
        set_l  = left_only & ~pend_r_q & (~pend_l_q | enq_l);
        set_r  = right_only & ~pend_l_q & (~pend_r_q | enq_r);
        clr_l  = enq_l | (right_only & pend_l_q);
        clr_r  = enq_r | (left_only & pend_r_q);
        drop_l = left_only & ~set_l;
        drop_r = right_only & ~set_r;
        drop_rot = rot_in & pend_rot_q & ~enq_rot;
        drop_dn  = dn_in & pend_dn_q & ~enq_dn;
        any_drop = drop_l | drop_r | drop_rot | drop_dn;

        pend_l_d   = set_l | (pend_l_q & ~clr_l);
        pend_r_d   = set_r | (pend_r_q & ~clr_r);
        pend_rot_d = rot_in | (pend_rot_q & ~enq_rot);
        pend_dn_d  = dn_in | (pend_dn_q & ~enq_dn);

        drop_d = drop_q;
        if (any_drop && drop_q != 8'hff) begin
            drop_d = drop_q + 8'd1;
        end

        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        if (flush) begin
            pend_l_d   = 1'b0;
            pend_r_d   = 1'b0;
            pend_rot_d = 1'b0;
            pend_dn_d  = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_l_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            pend_rot_q <= 1'b0;
            pend_dn_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
        end else begin
            pend_l_q   <= pend_l_d;
            pend_r_q   <= pend_r_d;
            pend_rot_q <= pend_rot_d;
            pend_dn_q  <= pend_dn_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
        end
    end

    // Storage is reset so cmd_code reads 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    assign cmd_valid  = (level_q != '0);
    assign cmd_code   = mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_move_cmd_dispatcher.sv
// Directed self-checking bench for move_cmd_dispatcher: latency, priority,
// opposing presses, full-FIFO hold, flush, drop saturation and async reset.
module tb_move_cmd_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_left_pulse, btn_right_pulse, btn_rotate_pulse, btn_down_pulse;
    logic       flush, cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [2:0] fifo_level;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    move_cmd_dispatcher #(.ADDR_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_left_pulse   (btn_left_pulse),
        .btn_right_pulse  (btn_right_pulse),
        .btn_rotate_pulse (btn_rotate_pulse),
        .btn_down_pulse   (btn_down_pulse),
        .flush            (flush),
        .cmd_valid        (cmd_valid),
        .cmd_code         (cmd_code),
        .cmd_ready        (cmd_ready),
        .fifo_level       (fifo_level),
        .drop_cnt         (drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        btn_left_pulse = 0; btn_right_pulse = 0; btn_rotate_pulse = 0; btn_down_pulse = 0;
        flush = 0; cmd_ready = 0;
        reset = 1;
        #3;
        reset = 0;
        step();
    endtask

    task automatic test_reset();
        reset = 1;
        btn_left_pulse = 0; btn_right_pulse = 0; btn_rotate_pulse = 0; btn_down_pulse = 0;
        flush = 0; cmd_ready = 0;
        #12;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d want=0", cmd_valid); end
        total++; if (cmd_code !== 2'd0) begin bad++; $display("FAIL rst_code got=%0d want=0", cmd_code); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", fifo_level); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop got=%0d want=0", drop_cnt); end
        reset = 0;
        step();
    endtask

    task automatic test_single_right();
        apply_reset();
        cmd_ready = 1;
        btn_right_pulse = 1;
        step();
        btn_right_pulse = 0;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL right_early got=%0d want=0", cmd_valid); end
        step();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL right_valid got=%0d want=1", cmd_valid); end
        total++; if (cmd_code !== 2'd1) begin bad++; $display("FAIL right_code got=%0d want=1", cmd_code); end
        total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL right_level got=%0d want=1", fifo_level); end
        step();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL right_one_cycle got=%0d want=0", cmd_valid); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL right_level0 got=%0d want=0", fifo_level); end
        step();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL right_stay0 got=%0d want=0", cmd_valid); end
    endtask

    task automatic test_priority();
        logic [1:0] exp_codes [3];
        exp_codes[0] = 2'd2; exp_codes[1] = 2'd0; exp_codes[2] = 2'd3;
        apply_reset();
        btn_rotate_pulse = 1; btn_left_pulse = 1; btn_down_pulse = 1;
        step();
        btn_rotate_pulse = 0; btn_left_pulse = 0; btn_down_pulse = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (fifo_level !== 3'(i)) begin bad++; $display("FAIL prio_level%0d got=%0d want=%0d", i, fifo_level, i); end
        end
        step();
        total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL prio_hold got=%0d want=3", fifo_level); end
        cmd_ready = 1;
        for (int i = 0; i < 3; i++) begin
            total++; if (cmd_valid !== 1'b1 || cmd_code !== exp_codes[i]) begin
                bad++; $display("FAIL prio_code%0d got=%0d/%0d want=1/%0d", i, cmd_valid, cmd_code, exp_codes[i]);
            end
            step();
        end
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL prio_empty got=%0d want=0", cmd_valid); end
    endtask

    task automatic test_opposing();
        apply_reset();
        // Fill the FIFO with four rotates so later flags stay pending.
        btn_rotate_pulse = 1;
        repeat (4) step();
        btn_rotate_pulse = 0;
        step();
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL opp_full got=%0d want=4", fifo_level); end
        btn_left_pulse = 1; btn_right_pulse = 1;
        step();
        btn_left_pulse = 0; btn_right_pulse = 0;
        step();
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL opp_lr_drop got=%0d want=0", drop_cnt); end
        btn_left_pulse = 1;
        step();
        btn_left_pulse = 0;
        step();
        btn_right_pulse = 1;
        step();
        btn_right_pulse = 0;
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL opp_cancel_drop got=%0d want=1", drop_cnt); end
        cmd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            total++; if (cmd_valid !== 1'b1 || cmd_code !== 2'd2) begin
                bad++; $display("FAIL opp_drain%0d got=%0d/%0d want=1/2", i, cmd_valid, cmd_code);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL opp_no_cmd%0d got=%0d want=0", i, cmd_valid); end
            step();
        end
    endtask

    task automatic test_full_hold();
        apply_reset();
        for (int p = 0; p < 6; p++) begin
            btn_down_pulse = 1;
            step();
            btn_down_pulse = 0;
            step();
            step();
        end
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d want=4", fifo_level); end
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL full_drop got=%0d want=1", drop_cnt); end
        cmd_ready = 1;
        for (int i = 0; i < 5; i++) begin
            total++; if (cmd_valid !== 1'b1 || cmd_code !== 2'd3) begin
                bad++; $display("FAIL full_drain%0d got=%0d/%0d want=1/3", i, cmd_valid, cmd_code);
            end
            step();
        end
        total++; if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin
            bad++; $display("FAIL full_empty got=%0d/%0d want=0/0", cmd_valid, fifo_level);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        btn_rotate_pulse = 1; btn_left_pulse = 1; btn_down_pulse = 1;
        step();
        btn_rotate_pulse = 0; btn_left_pulse = 0; btn_down_pulse = 0;
        repeat (3) step();
        total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d want=3", fifo_level); end
        flush = 1; btn_rotate_pulse = 1;
        step();
        flush = 0; btn_rotate_pulse = 0;
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL flush_level got=%0d want=0", fifo_level); end
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0d want=0", cmd_valid); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL flush_drop got=%0d want=0", drop_cnt); end
        repeat (4) step();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL flush_no_rot got=%0d want=0", cmd_valid); end
    endtask

    task automatic test_drop_sat_and_reset();
        apply_reset();
        btn_rotate_pulse = 1;
        // Edges 0..4 record or enqueue; every later edge is a drop.
        repeat (100) step();
        total++; if (drop_cnt !== 8'd95) begin bad++; $display("FAIL sat_mid got=%0d want=95", drop_cnt); end
        repeat (205) step();
        total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d want=255", drop_cnt); end
        repeat (20) step();
        total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", drop_cnt); end
        total++; if (fifo_level !== 3'd4 || cmd_code !== 2'd2) begin
            bad++; $display("FAIL sat_state got=%0d/%0d want=4/2", fifo_level, cmd_code);
        end
        #2;
        reset = 1;
        #1;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%0d want=0", cmd_valid); end
        total++; if (cmd_code !== 2'd0) begin bad++; $display("FAIL async_code got=%0d want=0", cmd_code); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL async_level got=%0d want=0", fifo_level); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL async_drop got=%0d want=0", drop_cnt); end
        btn_rotate_pulse = 0;
        #1;
        reset = 0;
        step();
        step();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL post_reset_lost got=%0d want=0", cmd_valid); end
    endtask

    initial begin
        test_reset();
        test_single_right();
        test_priority();
        test_opposing();
        test_full_hold();
        test_flush();
        test_drop_sat_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
